deserializer_sipo: RTL and testbench

DESERIALIZER_SIPO -- requirements
Module: deserializer_sipo

---
 rtl/deserializer_sipo.sv | 106 ++++++++++
 tb/tb_deserializer_sipo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_sipo.sv
// rtl/deserializer_sipo.sv - MSB-first serial-in/parallel-out deserializer with valid/ready output
// Optional feature macro: DESERIALIZER_PARITY_EN (adds a trailing even-parity bit per frame)
module deserializer_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  shift,
  input  logic                  frame_sync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  output logic                  parity_err
);

`ifdef DESERIALIZER_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  // The final bit of a frame is never stored: it is consumed combinationally
  // (as the data LSB, or as the parity bit), so the shifter is one bit short.
  localparam int SH_W = FRAME_LEN - 1;
  localparam int CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [CW-1:0]         r_cnt;
  logic [SH_W-1:0]       r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_perr;

  logic [CW-1:0]         w_base_cnt;
  logic [SH_W-1:0]       w_base_sh;
  logic                  w_last;
  logic                  w_complete;
  logic                  w_accept;
  logic [CW-1:0]         w_cnt_nxt;
  logic [SH_W-1:0]       w_sh_nxt;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_perr;

  // Frame assembly: realign on frame_sync, advance counter/shifter on shift, detect completion
  always_comb begin
    w_base_cnt = frame_sync ? '0 : r_cnt;
    w_base_sh  = frame_sync ? '0 : r_shreg;
    w_last     = (w_base_cnt == LAST_CNT);
    w_complete = shift && w_last;
    w_accept   = w_complete && (!r_valid || ready);
    w_cnt_nxt  = w_base_cnt;
    w_sh_nxt   = w_base_sh;
    if (shift) begin
      if (w_last) begin
        w_cnt_nxt = '0;
        w_sh_nxt  = '0;
      end else begin
        w_cnt_nxt = w_base_cnt + CW'(1);
        w_sh_nxt  = (w_base_sh << 1) | SH_W'(srl_in);
      end
    end
`ifdef DESERIALIZER_PARITY_EN
    w_word = w_base_sh;
    w_perr = (^w_base_sh) ^ srl_in;
`else
    w_word = {w_base_sh, srl_in};
    w_perr = 1'b0;
`endif
  end

  // State update: load on accepted completion, flag overrun on dropped word, clear valid on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_sh_nxt;
      if (w_accept) begin
        r_data  <= w_word;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else if (w_complete) begin
        r_overrun <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign overrun    = r_overrun;
`ifdef DESERIALIZER_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer_sipo.sv
// tb/tb_deserializer_sipo.sv - scoreboard testbench for deserializer_sipo
module tb_deserializer_sipo;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          srl_in = 1'b0;
  logic          shift = 1'b0;
  logic          frame_sync = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          overrun;
  logic          parity_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb_q[$];

  deserializer_sipo #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .srl_in(srl_in), .shift(shift), .frame_sync(frame_sync),
    .data_out(data_out), .valid(valid), .ready(ready), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops the expected word on every handshake the DUT will see at the next rising edge
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
      else chk("sb_data", 32'(data_out), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame MSB first; optionally ready on the final bit, frame_sync on the first,
  // idle gaps with toggling srl_in, and a deliberately wrong parity bit.
  task automatic send_word(input logic [DW-1:0] w, input bit rdy_last, input bit sync_first,
                           input bit gaps, input bit bad_par);
    int fl;
    logic p;
    p = (^w) ^ bad_par;
`ifdef DESERIALIZER_PARITY_EN
    fl = DW + 1;
`else
    fl = DW;
`endif
    for (int i = 0; i < fl; i++) begin
      srl_in     = (i < DW) ? w[DW-1-i] : p;
      shift      = 1'b1;
      frame_sync = (i == 0) && sync_first;
      ready      = (i == fl - 1) && rdy_last;
      tick();
      frame_sync = 1'b0;
      ready      = 1'b0;
      if (gaps && i < fl - 1) begin
        shift  = 1'b0;
        srl_in = ~w[DW-1-i];
        tick();
        srl_in = w[DW-1-i];
        tick();
      end
    end
    shift = 1'b0;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      srl_in = w[DW-1-i];
      shift  = 1'b1;
      tick();
    end
    shift = 1'b0;
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    chk("watchdog", 32'h1, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    pulse_reset();

    // Basic 0xA5 frame, then handshake clears valid
    sb_q.push_back(8'hA5);
    send_word(8'hA5, 0, 0, 0, 0);
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_perr", 32'(parity_err), 32'h0);
    consume();
    chk("a5_valid_clr", 32'(valid), 32'h0);
    chk("a5_no_ovr", 32'(overrun), 32'h0);

    // Held 0xA5, second frame 0x3C dropped
    sb_q.push_back(8'hA5);
    send_word(8'hA5, 0, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0, 0);
    chk("ovr_data_held", 32'(data_out), 32'hA5);
    chk("ovr_valid_held", 32'(valid), 32'h1);
    chk("ovr_set", 32'(overrun), 32'h1);
    consume();
    chk("ovr_valid_clr", 32'(valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    repeat (3) tick();
    chk("ovr_sticky2", 32'(overrun), 32'h1);

    // Simultaneous consume and completion
    pulse_reset();
    sb_q.push_back(8'h11);
    send_word(8'h11, 0, 0, 0, 0);
    sb_q.push_back(8'h22);
    send_word(8'h22, 1, 0, 0, 0);
    chk("swap_data", 32'(data_out), 32'h22);
    chk("swap_valid", 32'(valid), 32'h1);
    chk("swap_no_ovr", 32'(overrun), 32'h0);
    consume();

    // Partial frame discarded by frame_sync with shift=0; gaps ignore srl_in
    send_bits(8'hE0, 3);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sync_no_word", 32'(valid), 32'h0);
    sb_q.push_back(8'hC3);
    send_word(8'hC3, 0, 0, 1, 0);
    chk("sync_valid", 32'(valid), 32'h1);
    chk("sync_data", 32'(data_out), 32'hC3);
    consume();

    // frame_sync together with shift: that bit is bit 0 of the new frame
    send_bits(8'hFF, 2);
    sb_q.push_back(8'h96);
    send_word(8'h96, 0, 1, 0, 0);
    chk("sync_shift_data", 32'(data_out), 32'h96);
    chk("sync_shift_ovr", 32'(overrun), 32'h0);
    consume();

    // Reset mid-frame with a held word and overrun set
    send_word(8'h5A, 0, 0, 0, 0);
    send_word(8'h77, 0, 0, 0, 0);
    chk("pre_rst_ovr", 32'(overrun), 32'h1);
    send_bits(8'hFF, 5);
    sb_q.delete();
    pulse_reset();
    sb_q.push_back(8'h0F);
    send_word(8'h0F, 0, 0, 0, 0);
    chk("post_rst_data", 32'(data_out), 32'h0F);
    chk("post_rst_valid", 32'(valid), 32'h1);
    consume();

`ifdef DESERIALIZER_PARITY_EN
    sb_q.push_back(8'hA5);
    send_word(8'hA5, 0, 0, 0, 0);
    chk("par_good_perr", 32'(parity_err), 32'h0);
    consume();
    sb_q.push_back(8'hA5);
    send_word(8'hA5, 0, 0, 0, 1);
    chk("par_bad_perr", 32'(parity_err), 32'h1);
    chk("par_bad_data", 32'(data_out), 32'hA5);
    consume();
`else
    chk("noparity_perr", 32'(parity_err), 32'h0);
`endif

    repeat (2) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("final_valid", 32'(valid), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
